// File: rtl/dm_port_arbiter_pkg.sv
// Shared owner and FSM encodings for the data-memory port arbiter and core_top.
package dm_port_arbiter_pkg;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CORE  = 2'd1;
  localparam logic [1:0] ST_HOST  = 2'd2;
  localparam logic [1:0] ST_HLOCK = 2'd3;

endpackage

// File: rtl/dm_port_arbiter_rr_pick.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the side that did not own last.
module dm_port_arbiter_rr_pick
  import dm_port_arbiter_pkg::*;
(
  input  logic i_core_req,
  input  logic i_host_req,
  input  logic i_last_owner,
  output logic o_pick_core,
  output logic o_pick_host
);

  // Tie breaker against the last owner.
  always_comb begin
    o_pick_core = 1'b0;
    o_pick_host = 1'b0;
    if (i_core_req && i_host_req) begin
      if (i_last_owner == OWN_HOST) begin
        o_pick_core = 1'b1;
      end else begin
        o_pick_host = 1'b1;
      end
    end else begin
      o_pick_core = i_core_req;
      o_pick_host = i_host_req;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates core and host accesses onto a single-port data memory, with a bounded host burst lock.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int DMA_SIZE = 16,
  parameter int DMD_SIZE = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [DMA_SIZE-1:0] core_addr,
  input  logic [DMD_SIZE-1:0] core_wdata,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DMD_SIZE-1:0] core_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic                host_lock,
  input  logic [DMA_SIZE-1:0] host_addr,
  input  logic [DMD_SIZE-1:0] host_wdata,
  output logic                host_gnt,
  output logic                host_rvalid,
  output logic [DMD_SIZE-1:0] host_rdata,
  output logic                dm_en,
  output logic                dm_we,
  output logic [DMA_SIZE-1:0] dm_addr,
  output logic [DMD_SIZE-1:0] dm_wdata,
  input  logic [DMD_SIZE-1:0] dm_rdata
);

  localparam int              CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       r_state;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_lock_block;
  logic             r_rd_valid;
  logic             r_rd_owner;

  logic             w_rr_core;
  logic             w_rr_host;
  logic             w_gnt_core;
  logic             w_gnt_host;
  logic             w_force_exit;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_block_nxt;

  dm_port_arbiter_rr_pick u_rr_pick (
    .i_core_req   (core_req),
    .i_host_req   (host_req),
    .i_last_owner (r_last_owner),
    .o_pick_core  (w_rr_core),
    .o_pick_host  (w_rr_host)
  );

  // Grant selection; a saturated lock yields to a waiting core for one forced grant.
  always_comb begin
    w_force_exit = 1'b0;
    w_gnt_core   = 1'b0;
    w_gnt_host   = 1'b0;
    if (reset == 1'b0) begin
      w_gnt_core = 1'b0;
    end else if (r_state == ST_HLOCK) begin
      if ((r_lock_cnt == CNT_MAX) && core_req) begin
        w_force_exit = 1'b1;
        w_gnt_core   = 1'b1;
      end else if (host_req) begin
        w_gnt_host = 1'b1;
      end else begin
        w_gnt_core = core_req;
      end
    end else begin
      w_gnt_core = w_rr_core;
      w_gnt_host = w_rr_host;
    end
  end

  // Next FSM state, lock count and post-exit lock suppression.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = CNT_ZERO;
    w_block_nxt = r_lock_block;
    if (w_gnt_core) begin
      w_state_nxt = ST_CORE;
      w_block_nxt = w_force_exit;
    end else if (w_gnt_host) begin
      if (host_lock && !r_lock_block) begin
        w_state_nxt = ST_HLOCK;
        if (r_state != ST_HLOCK) begin
          w_cnt_nxt = CNT_ONE;
        end else if (r_lock_cnt == CNT_MAX) begin
          w_cnt_nxt = r_lock_cnt;
        end else begin
          w_cnt_nxt = r_lock_cnt + CNT_ONE;
        end
      end else begin
        w_state_nxt = ST_HOST;
      end
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Arbitration state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= OWN_HOST;
      r_lock_cnt   <= CNT_ZERO;
      r_lock_block <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_cnt_nxt;
      r_lock_block <= w_block_nxt;
      if (w_gnt_core) begin
        r_last_owner <= OWN_CORE;
      end else if (w_gnt_host) begin
        r_last_owner <= OWN_HOST;
      end
    end
  end

  // Read-return tracking: the memory answers one cycle after a read transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_owner <= OWN_CORE;
    end else begin
      r_rd_valid <= dm_en && !dm_we;
      if (dm_en && !dm_we) begin
        r_rd_owner <= w_gnt_host ? OWN_HOST : OWN_CORE;
      end
    end
  end

  // Memory port mux from the granted side.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = {DMA_SIZE{1'b0}};
    dm_wdata = {DMD_SIZE{1'b0}};
    if (w_gnt_core) begin
      dm_we    = core_we;
      dm_addr  = core_addr;
      dm_wdata = core_wdata;
    end else if (w_gnt_host) begin
      dm_we    = host_we;
      dm_addr  = host_addr;
      dm_wdata = host_wdata;
    end else begin
      dm_we    = 1'b0;
    end
  end

  assign core_gnt    = w_gnt_core;
  assign host_gnt    = w_gnt_host;
  assign dm_en       = w_gnt_core | w_gnt_host;
  assign core_rvalid = r_rd_valid && (r_rd_owner == OWN_CORE);
  assign host_rvalid = r_rd_valid && (r_rd_owner == OWN_HOST);
  assign core_rdata  = core_rvalid ? dm_rdata : {DMD_SIZE{1'b0}};
  assign host_rdata  = host_rvalid ? dm_rdata : {DMD_SIZE{1'b0}};

endmodule

// File: doc/dm_port_arbiter.md
DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 Parameter DMA_SIZE, default 16: data-memory address width.
REQ-002 Parameter DMD_SIZE, default 16: data-memory data width.
REQ-003 Parameter LOCK_MAX, default 8: maximum consecutive host grants under host_lock.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 core_req / core_we  in  1 / 1  core data-path access request / write qualifier.
REQ-007 core_addr / core_wdata  in  DMA_SIZE / DMD_SIZE  core address / write data.
REQ-008 core_gnt  out  1  core request accepted this cycle.
REQ-009 core_rvalid / core_rdata  out  1 / DMD_SIZE  core read-return strobe / read data.
REQ-010 host_req / host_we / host_lock  in  1 / 1 / 1  host (loader/debug) request / write / burst-lock.
REQ-011 host_addr / host_wdata  in  DMA_SIZE / DMD_SIZE  host address / write data.
REQ-012 host_gnt  out  1  host request accepted this cycle.
REQ-013 host_rvalid / host_rdata  out  1 / DMD_SIZE  host read-return strobe / read data.
REQ-014 dm_en / dm_we  out  1 / 1  single-port data-memory enable / write enable.
REQ-015 dm_addr / dm_wdata  out  DMA_SIZE / DMD_SIZE  data-memory address / write data.
REQ-016 dm_rdata  in  DMD_SIZE  data-memory read data, valid one cycle after a read dm_en.

Function
REQ-017 Grant is combinational from req and registered state; a transfer occurs when req and gnt are both high; requester holds req/we/addr/wdata stable until gnt.
REQ-018 At most one of core_gnt, host_gnt is high per cycle; dm_en equals core_gnt OR host_gnt; dm_we/dm_addr/dm_wdata are muxed from the granted side, else all zero.
REQ-019 Registered last_owner (CORE/HOST): with both requesting and no active lock, grant goes to the side that is not last_owner; last_owner updates only on a transfer.
REQ-020 Single requester is granted immediately regardless of last_owner.
REQ-021 FSM states IDLE, CORE, HOST, HLOCK: IDLE/CORE/HOST reflect last cycle's transfer owner (IDLE when none); HLOCK entered on host transfer with host_lock high.
REQ-022 In HLOCK, host has absolute priority; lock_cnt (width clog2(LOCK_MAX+1)) counts host transfers, starting at 1 on entry.
REQ-023 HLOCK exits to HOST when host_lock drops, to IDLE when host_req drops, or forced when lock_cnt reaches LOCK_MAX and core_req is high; forced exit grants core next cycle and host_lock is ignored until one core transfer completes.
REQ-024 Read return: registered rd_owner captured on a read transfer; next cycle assert the matching *_rvalid for one cycle and drive dm_rdata to that side's rdata; other side's rdata is zero.
REQ-025 Back-to-back transfers every cycle are supported; read return and new grant overlap without stall.
REQ-026 Write transfers produce no rvalid.

Reset
REQ-027 On reset low: FSM=IDLE, last_owner=HOST (core wins first tie), lock_cnt=0, rd_owner cleared, all *_gnt, *_rvalid, dm_en, dm_we = 0, all data/address outputs = 0.
REQ-028 Reset asserted mid-transfer discards any pending read return; no rvalid after reset release until a new read transfer.

Structure
REQ-029 Owner encoding (CORE, HOST) and FSM state encoding reside in a shared package used with core_top.
REQ-030 No sub-module required; optional rr_pick sub-module for the two-way round-robin select.

Verification
REQ-031 Reset, then core read addr 0x0010 alone -> core_gnt same cycle, core_rvalid next cycle with DM contents of 0x0010.
REQ-032 Both request continuously after reset -> grants alternate core, host, core, host; no cycle with both gnt.
REQ-033 host_lock=1, both requesting, LOCK_MAX=8 -> 8 consecutive host_gnt, then core_gnt, then alternation resumes.
REQ-034 Host write 0xBEEF to 0x0004, then core read 0x0004 next cycle -> core_rdata 0xBEEF, host_rvalid never high.
REQ-035 Reset pulsed low the cycle after a host read grant -> host_rvalid stays 0, all outputs zero during reset.
